// File: rtl/morse_playback.sv
// morse_playback: plays three stored 10-bit Morse letters as a timed on/off
// signal. Each letter holds five 2-bit symbols, MSB pair first:
// 00 = dot, 01 = dash, 1x = end of letter. Timing is measured in units of
// UNIT_CYCLES clocks: dot 1, dash 3, intra-letter gap 1, inter-letter gap 3.
// Optional build macro MORSE_PLAYBACK_REPEAT_EN: while start stays high at the
// end of a pass, a 7-unit word gap is inserted and the stored word replays.
module morse_playback #(
  parameter int UNIT_CYCLES = 25000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [29:0] seqs_in,
  output logic        tone_out,
  output logic        busy,
  output logic        done,
  output logic [1:0]  letter_idx
);

  localparam int CW = $clog2(7 * UNIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] UNIT_1  = CW'(UNIT_CYCLES);
  localparam logic [CW-1:0] UNIT_3  = CW'(3 * UNIT_CYCLES);
  localparam logic [CW-1:0] UNIT_7  = CW'(7 * UNIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MARK   = 2'd1,
    GAP    = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      pos_q, pos_d;        // symbol index 0..14 of current/next mark
  logic            pend_q, pend_d;      // trigger seen, shadow just loaded
  logic            wgap_q, wgap_d;      // current GAP is a word gap
  logic [29:0]     sh_q, sh_d;          // shadow copy of the stored word
  logic            start_q, start_d;    // previous start level for edge detect
  logic            tone_q, tone_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [1:0]      letter_q, letter_d;

  logic [14:0]     mark_mask_s;         // symbol j is a playable mark
  logic            first_found_s, next_found_s, end_s;
  logic [3:0]      first_idx_s, next_idx_s;

  // Letter number (0..2) that owns flat symbol index idx (0..14).
  function automatic logic [1:0] letter_of(input logic [3:0] idx);
    if (idx < 4'd5) begin
      return 2'd0;
    end else if (idx < 4'd10) begin
      return 2'd1;
    end else begin
      return 2'd2;
    end
  endfunction

  // Mark length in clocks for the symbol at flat index idx of word sh.
  function automatic logic [CW-1:0] mark_len(input logic [29:0] sh, input logic [3:0] idx);
    logic [29:0] shifted;
    shifted = sh << {idx, 1'b0};
    if (shifted[29:28] == 2'b01) begin
      return UNIT_3;
    end else begin
      return UNIT_1;
    end
  endfunction

  // Flag every symbol that is a dot/dash not preceded by an end code in its letter.
  always_comb begin : mask_comb
    logic live;
    mark_mask_s = 15'd0;
    live        = 1'b1;
    for (int l = 0; l < 3; l++) begin
      live = 1'b1;
      for (int s = 0; s < 5; s++) begin
        if (live && !sh_q[5'(29 - 10 * l - 2 * s)]) begin
          mark_mask_s[4'(5 * l + s)] = 1'b1;
        end else begin
          live = 1'b0;
        end
      end
    end
  end

  // Priority search: first mark of the word and first mark after pos_q.
  always_comb begin
    first_found_s = 1'b0;
    first_idx_s   = 4'd0;
    next_found_s  = 1'b0;
    next_idx_s    = 4'd0;
    for (int j = 14; j >= 0; j--) begin
      if (mark_mask_s[4'(j)]) begin
        first_found_s = 1'b1;
        first_idx_s   = 4'(j);
        if (j > int'(pos_q)) begin
          next_found_s = 1'b1;
          next_idx_s   = 4'(j);
        end else begin
          next_found_s = next_found_s;
        end
      end else begin
        first_found_s = first_found_s;
      end
    end
  end

  // Next-state logic for the playback FSM and the registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    pend_d  = 1'b0;
    wgap_d  = wgap_q;
    sh_d    = sh_q;
    start_d = start;
    end_s   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_q) begin
          if (first_found_s) begin
            state_d = MARK;
            pos_d   = first_idx_s;
            cnt_d   = mark_len(sh_q, first_idx_s);
            wgap_d  = 1'b0;
          end else begin
            end_s = 1'b1;
          end
        end else if (start && !start_q) begin
          sh_d   = seqs_in;
          pend_d = 1'b1;
        end else begin
          sh_d = sh_q;
        end
      end
      MARK: begin
        if (cnt_q == CNT_ONE) begin
          if (next_found_s) begin
            state_d = GAP;
            pos_d   = next_idx_s;
            wgap_d  = 1'b0;
            cnt_d   = (letter_of(next_idx_s) == letter_of(pos_q)) ? UNIT_1 : UNIT_3;
          end else begin
            end_s = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      GAP: begin
        if (cnt_q == CNT_ONE) begin
          if (!wgap_q) begin
            state_d = MARK;
            cnt_d   = mark_len(sh_q, pos_q);
          end else if (start && first_found_s) begin
            state_d = MARK;
            pos_d   = first_idx_s;
            wgap_d  = 1'b0;
            cnt_d   = mark_len(sh_q, first_idx_s);
          end else begin
            end_s = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      FINISH: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
        pos_d   = 4'd0;
        wgap_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
        pos_d   = 4'd0;
        wgap_d  = 1'b0;
      end
    endcase

    // End of a pass: finish, or (repeat build) word gap while start is held.
    if (end_s) begin
`ifdef MORSE_PLAYBACK_REPEAT_EN
      if (start) begin
        state_d = GAP;
        wgap_d  = 1'b1;
        cnt_d   = UNIT_7;
        pos_d   = first_idx_s;
      end else begin
        state_d = FINISH;
        wgap_d  = 1'b0;
        cnt_d   = {CW{1'b0}};
      end
`else
      state_d = FINISH;
      wgap_d  = 1'b0;
      cnt_d   = {CW{1'b0}};
`endif
    end else begin
      wgap_d = wgap_d;
    end

    tone_d = (state_d == MARK);
    busy_d = (state_d == MARK) || (state_d == GAP);
    done_d = (state_d == FINISH);
    if (busy_d) begin
      letter_d = letter_of(pos_d);
    end else begin
      letter_d = 2'd0;
    end
  end

  // State, shadow and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= {CW{1'b0}};
      pos_q    <= 4'd0;
      pend_q   <= 1'b0;
      wgap_q   <= 1'b0;
      sh_q     <= {30{1'b1}};
      start_q  <= 1'b1;
      tone_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      letter_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      pend_q   <= pend_d;
      wgap_q   <= wgap_d;
      sh_q     <= sh_d;
      start_q  <= start_d;
      tone_q   <= tone_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      letter_q <= letter_d;
    end
  end

  assign tone_out   = tone_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign letter_idx = letter_q;

endmodule

// File: tb/tb_morse_playback.sv
// Bench for morse_playback with UNIT_CYCLES=4. A per-cycle expectation queue
// is built from the Morse timing rules and checked on every falling edge.
module tb_morse_playback;

  localparam int U = 4;
  localparam logic [29:0] W_SOS   = 30'b0000001111_0101011111_0000001111;
  localparam logic [29:0] W_EMPTY = 30'b1111111111_1111111111_1111111111;
  localparam logic [29:0] W_SO    = 30'b0000001111_1111111111_0101011111;
  localparam logic [29:0] W_RSV   = 30'b0010111111_1111111111_1111111111;
  localparam logic [29:0] W_E     = 30'b0011111111_1111111111_1111111111;

  typedef struct packed {
    logic       tone;
    logic       busy;
    logic       done;
    logic [1:0] idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [29:0] seqs_in;
  logic        tone_out;
  logic        busy;
  logic        done;
  logic [1:0]  letter_idx;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  morse_playback #(.UNIT_CYCLES(U)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .seqs_in    (seqs_in),
    .tone_out   (tone_out),
    .busy       (busy),
    .done       (done),
    .letter_idx (letter_idx)
  );

  always #5 clk = ~clk;

  // Compare DUT outputs with the expectation queue every cycle (idle when empty).
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n || exp_q.size() == 0) begin
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    checks++;
    if ({tone_out, busy, done, letter_idx} !== e) begin
      errors++;
      $display("FAIL cycle_chk t=%0t got tone=%b busy=%b done=%b idx=%0d exp tone=%b busy=%b done=%b idx=%0d",
               $time, tone_out, busy, done, letter_idx, e.tone, e.busy, e.done, e.idx);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  task automatic push_n(input int n, input logic t, input logic b, input logic d, input int idx);
    exp_t e;
    e.tone = t; e.busy = b; e.done = d; e.idx = 2'(idx);
    for (int k = 0; k < n; k++) exp_q.push_back(e);
  endtask

  // Expected waveform from the Morse rules: marks per letter, gaps, word gaps, done.
  task automatic push_model(input logic [29:0] w, input int reps, output int blen);
    int         mlen[$];
    int         mlet[$];
    logic [1:0] sym;
    bit         live;
    blen = 0;
    for (int l = 0; l < 3; l++) begin
      live = 1'b1;
      for (int s = 0; s < 5; s++) begin
        sym = w[29 - 10 * l - 2 * s -: 2];
        if (live && sym[1] == 1'b0) begin
          mlen.push_back(sym == 2'b01 ? 3 * U : U);
          mlet.push_back(l);
        end else begin
          live = 1'b0;
        end
      end
    end
    for (int r = 0; r < reps; r++) begin
      if (r > 0) begin
        push_n(7 * U, 1'b0, 1'b1, 1'b0, mlet[0]);
        blen += 7 * U;
      end
      for (int i = 0; i < mlen.size(); i++) begin
        if (i > 0) begin
          int g;
          g = (mlet[i] == mlet[i-1]) ? U : 3 * U;
          push_n(g, 1'b0, 1'b1, 1'b0, mlet[i]);
          blen += g;
        end
        push_n(mlen[i], 1'b1, 1'b1, 1'b0, mlet[i]);
        blen += mlen[i];
      end
    end
    push_n(1, 1'b0, 1'b0, 1'b1, 0);
  endtask

  // One playback: rising start at edge N, seqs_in scrambled after latching.
  task automatic play(input logic [29:0] w, input int reps, input int drop_c,
                      input bit retrig, input int exp_busy, input string name);
    int blen;
    int nb;
    bit seen;
    @(posedge clk); #1;
    seqs_in = w;
    start   = 1'b1;
    push_n(2, 1'b0, 1'b0, 1'b0, 0);
    push_model(w, reps, blen);
    chk({name, "_model_len"}, blen, exp_busy);
    nb   = 0;
    seen = 1'b0;
    for (int c = 0; c < 600 && !seen; c++) begin
      @(posedge clk); #1;
      seqs_in = 30'($urandom);
      if (c == drop_c) start = 1'b0;
      if (retrig && c == 10) start = 1'b1;
      if (retrig && c == 20) start = 1'b0;
      @(negedge clk);
      if (busy) nb++;
      if (done) seen = 1'b1;
    end
    chk({name, "_done_seen"}, int'(seen), 1);
    chk({name, "_busy_cycles"}, nb, exp_busy);
    if (!seen) exp_q.delete();
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int blen;
    reset_n = 1'b0;
    start   = 1'b1;
    seqs_in = 30'd0;
    #2;
    chk("reset_state", int'({tone_out, busy, done, letter_idx}), 0);
    #20;
    reset_n = 1'b1;
    // start held high through reset release: compare process expects idle.
    repeat (10) @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);

    play(W_SOS,   1, 0, 1'b0, 108, "sos");
    play(W_EMPTY, 1, 0, 1'b0, 0,   "empty");
    play(W_SO,    1, 0, 1'b0, 76,  "s_empty_o");
    play(W_RSV,   1, 0, 1'b0, 4,   "reserved");
    play(W_SOS,   1, 0, 1'b1, 108, "retrigger");

`ifdef MORSE_PLAYBACK_REPEAT_EN
    play(W_E, 2, 34, 1'b0, 36, "hold_repeat");
`else
    play(W_E, 1, -1, 1'b0, 4, "hold_single");
    repeat (20) @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
`endif

    // Reset asserted in the middle of the first O dash.
    @(posedge clk); #1;
    seqs_in = W_SOS;
    start   = 1'b1;
    push_n(2, 1'b0, 1'b0, 1'b0, 0);
    push_model(W_SOS, 1, blen);
    for (int c = 0; c <= 35; c++) begin
      @(posedge clk); #1;
      if (c == 0) start = 1'b0;
    end
    #1;
    chk("mid_dash_tone", int'(tone_out), 1);
    chk("mid_dash_idx", int'(letter_idx), 1);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_reset_tone", int'(tone_out), 0);
    chk("async_reset_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (15) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Bound the whole run.
  initial begin
    #1000000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end

endmodule
